rand_mod_picker: RTL

RAND_MOD_PICKER -- requirements
Module: rand_mod_picker

---
 rtl/rand_pkg.sv | 29 ++
 rtl/rand_fifo.sv | 59 +++++
 rtl/rand_mod_picker.sv | 123 ++++++++++++
 3 files changed

// File: rtl/rand_pkg.sv
// Shared types and parameter helpers for the modulo-reducing random picker.
package rand_pkg;

  // Default geometry: 15-bit LFSR word reduced into 25 slots, 4-deep output FIFO.
  localparam int DEF_IN_W    = 15;
  localparam int DEF_MODULUS = 25;
  localparam int DEF_OUT_W   = 5;
  localparam int DEF_DEPTH   = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_CAPT,
    ST_RED,
    ST_PUSH
  } state_e;

  // Largest multiple of the modulus that fits in the raw word range; samples
  // at or above it are rejected so every slot is equally likely.
  function automatic int calc_limit(input int in_w, input int modulus);
    return ((1 << in_w) / modulus) * modulus;
  endfunction

  // Highest shift used by the restoring reduction (MODULUS << K still fits IN_W bits).
  function automatic int calc_k(input int in_w, input int out_w);
    return in_w - out_w;
  endfunction

endpackage

// File: rtl/rand_fifo.sv
// Small first-word-fall-through FIFO holding finished picks.
module rand_fifo #(
  parameter int WIDTH = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);

  // Storage is tiny and read combinationally so the head is visible with valid.
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = count_q;
  // Reads as zero while empty so the output is clean after reset.
  assign dout    = empty ? '0 : mem_q[rd_ptr_q];

  // Write the incoming pick at the tail.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/rand_mod_picker.sv
// Draws LFSR samples, rejects biased ones, reduces the rest modulo MODULUS by
// shift-and-subtract, and queues the picks in a FWFT FIFO.
module rand_mod_picker
  import rand_pkg::*;
#(
  parameter int IN_W    = DEF_IN_W,
  parameter int MODULUS = DEF_MODULUS,
  parameter int OUT_W   = DEF_OUT_W,
  parameter int DEPTH   = DEF_DEPTH
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run,
  output logic            rng_en,
  input  logic [IN_W-1:0] rng_in,
  output logic [OUT_W-1:0] out_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [7:0]      reject_cnt
);

  localparam int K     = calc_k(IN_W, OUT_W);
  localparam int LIMIT = calc_limit(IN_W, MODULUS);
  localparam int K_W   = $clog2(K + 2);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // One spare bit so MODULUS << k and the raw sample never overflow.
  localparam logic [IN_W:0] MOD_EXT   = (IN_W+1)'(MODULUS);
  localparam logic [IN_W:0] LIMIT_EXT = (IN_W+1)'(LIMIT);

  state_e           state_q;
  logic [IN_W:0]    r_q;
  logic [IN_W:0]    r_d;
  logic [IN_W:0]    sub_d;
  logic [K_W-1:0]   k_q;
  logic [7:0]       rej_q;
  logic             rng_en_q;
  logic             fifo_push;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;

  // One restoring-reduction step: subtract MODULUS << k when it fits.
  always_comb begin
    sub_d = MOD_EXT << k_q;
    r_d   = r_q;
    if (r_q >= sub_d) begin
      r_d = r_q - sub_d;
    end
  end

  // Sampling FSM: request, capture/reject, K+1 reduction steps, push.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      r_q      <= '0;
      k_q      <= '0;
      rej_q    <= '0;
      rng_en_q <= 1'b0;
    end else begin
      rng_en_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (run && (fifo_count < CNT_W'(DEPTH))) begin
            state_q  <= ST_REQ;
            rng_en_q <= 1'b1;
          end
        end
        ST_REQ: begin
          state_q <= ST_CAPT;
        end
        ST_CAPT: begin
          r_q <= {1'b0, rng_in};
          k_q <= K_W'(K);
          if ({1'b0, rng_in} >= LIMIT_EXT) begin
            if (rej_q != 8'hFF) rej_q <= rej_q + 8'd1;
            state_q  <= ST_REQ;
            rng_en_q <= 1'b1;
          end else begin
            state_q <= ST_RED;
          end
        end
        ST_RED: begin
          r_q <= r_d;
          if (k_q == '0) begin
            state_q <= ST_PUSH;
          end else begin
            k_q <= k_q - 1'b1;
          end
        end
        ST_PUSH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // The IDLE space check already prevents a push into a full FIFO; the extra
  // term only keeps the write strobe self-evidently safe.
  assign fifo_push  = (state_q == ST_PUSH) && !fifo_full;
  assign rng_en     = rng_en_q;
  assign reject_cnt = rej_q;
  assign out_valid  = !fifo_empty;

  rand_fifo #(
    .WIDTH (OUT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (fifo_push),
    .din   (r_q[OUT_W-1:0]),
    .pop   (out_ready),
    .dout  (out_data),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule
